// File: rtl/fifo_btn_ctrl.sv
// Button-driven FIFO controller: synchronised single-shot button accesses,
// first-word-fall-through read data, occupancy count, threshold and sticky error flags.
module fifo_btn_ctrl #(
    parameter int unsigned B      = 3,
    parameter int unsigned W      = 2,
    parameter int unsigned AF_LVL = 3,
    parameter int unsigned AE_LVL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_rd,
    input  logic         btn_wr,
    input  logic [B-1:0] sw,
    input  logic         clr_err,
    output logic [B-1:0] r_data,
    output logic [W:0]   count,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic         ovf,
    output logic         udf
);

    localparam int unsigned DEPTH = 2 ** W;
    localparam int unsigned CW    = W + 1;

    // Threshold ordering must hold for the flags to be meaningful.
    if (!((AE_LVL < AF_LVL) && (AF_LVL <= DEPTH))) begin : g_bad_param
        $error("fifo_btn_ctrl: illegal AE_LVL/AF_LVL for depth 2**W");
    end

    logic [B-1:0]  mem [DEPTH];
    logic [W-1:0]  w_ptr;
    logic [W-1:0]  r_ptr;
    logic [CW-1:0] count_nxt;

    // Bit 0 is the read button, bit 1 the write button.
    logic [1:0] sync0;
    logic [1:0] sync1;
    logic [1:0] prev;
    logic [1:0] tick;
    logic       rd_tick;
    logic       wr_tick;
    logic       do_wr;
    logic       do_rd;
    logic       set_ovf;
    logic       set_udf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0 <= '0;
            sync1 <= '0;
            prev  <= '0;
        end else begin
            sync0 <= {btn_wr, btn_rd};
            sync1 <= sync0;
            prev  <= sync1;
        end
    end

    assign tick    = sync1 & ~prev;
    assign rd_tick = tick[0];
    assign wr_tick = tick[1];

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign do_wr   = wr_tick & (~full | rd_tick);
    assign do_rd   = rd_tick & ~empty;
    assign set_ovf = wr_tick & full & ~rd_tick;
    assign set_udf = rd_tick & empty;

    always_comb begin
        count_nxt = count;
        if (do_wr && !do_rd) begin
            count_nxt = count + CW'(1);
        end else if (do_rd && !do_wr) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage carries no reset; empty masks stale contents on r_data.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[w_ptr] <= sw;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                w_ptr <= w_ptr + W'(1);
            end
            if (do_rd) begin
                r_ptr <= r_ptr + W'(1);
            end
            count <= count_nxt;
        end
    end

    // Flags are registered from the next count so they move together with count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == CW'(0));
            almost_full  <= (count_nxt >= CW'(AF_LVL));
            almost_empty <= (count_nxt <= CW'(AE_LVL));
        end
    end

    // Sticky errors: a new error in the clearing cycle wins over clr_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= set_ovf | (ovf & ~clr_err);
            udf <= set_udf | (udf & ~clr_err);
        end
    end

    assign r_data = empty ? '0 : mem[r_ptr];

endmodule

// File: tb/tb_fifo_btn_ctrl.sv
// Directed bench for fifo_btn_ctrl at default parameters (B=3, W=2, AF=3, AE=1).
module tb_fifo_btn_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_rd;
    logic       btn_wr;
    logic [2:0] sw;
    logic       clr_err;
    logic [2:0] r_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       ovf;
    logic       udf;

    int checks = 0;
    int errors = 0;

    fifo_btn_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .btn_rd       (btn_rd),
        .btn_wr       (btn_wr),
        .sw           (sw),
        .clr_err      (clr_err),
        .r_data       (r_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rise, hold two edges, release; commit edge optionally carries clr_err.
    task automatic press(input logic rd, input logic wr, input logic [2:0] d, input logic clr);
        sw     = d;
        btn_rd = rd;
        btn_wr = wr;
        cyc(2);
        btn_rd  = 1'b0;
        btn_wr  = 1'b0;
        clr_err = clr;
        cyc(1);
        clr_err = 1'b0;
        cyc(2);
    endtask

    initial begin
        reset   = 1'b0;
        btn_rd  = 1'b0;
        btn_wr  = 1'b0;
        sw      = 3'd0;
        clr_err = 1'b0;
        cyc(2);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_afull", 32'(almost_full), 32'd0);
        chk("rst_rdata", 32'(r_data), 32'd0);
        reset = 1'b1;
        cyc(2);

        // Test 1: reset mid-stream with two words queued
        press(1'b0, 1'b1, 3'd1, 1'b0);
        press(1'b0, 1'b1, 3'd2, 1'b0);
        chk("t1_count2", 32'(count), 32'd2);
        chk("t1_aempty_off", 32'(almost_empty), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("t1_async_count", 32'(count), 32'd0);
        chk("t1_async_empty", 32'(empty), 32'd1);
        chk("t1_async_aempty", 32'(almost_empty), 32'd1);
        chk("t1_async_rdata", 32'(r_data), 32'd0);
        chk("t1_async_ovf", 32'(ovf), 32'd0);
        chk("t1_async_udf", 32'(udf), 32'd0);
        cyc(1);
        reset = 1'b1;
        cyc(1);
        press(1'b0, 1'b1, 3'd5, 1'b0);
        chk("t1_rdata5", 32'(r_data), 32'd5);
        chk("t1_count1", 32'(count), 32'd1);
        press(1'b1, 1'b0, 3'd0, 1'b0);
        chk("t1_drain_empty", 32'(empty), 32'd1);
        chk("t1_drain_rdata", 32'(r_data), 32'd0);

        // Test 2: held write button gives a single access, committing two edges after rise
        sw     = 3'd3;
        btn_wr = 1'b1;
        cyc(1);
        chk("t2_edge_k", 32'(count), 32'd0);
        cyc(1);
        chk("t2_edge_k1", 32'(count), 32'd0);
        cyc(1);
        chk("t2_edge_k2", 32'(count), 32'd1);
        chk("t2_rdata", 32'(r_data), 32'd3);
        cyc(17);
        btn_wr = 1'b0;
        cyc(3);
        chk("t2_held_count", 32'(count), 32'd1);
        press(1'b1, 1'b0, 3'd0, 1'b0);
        chk("t2_drain", 32'(count), 32'd0);

        // Test 3: fill, overflow, drain
        press(1'b0, 1'b1, 3'd1, 1'b0);
        chk("t3_c1_aempty", 32'(almost_empty), 32'd1);
        press(1'b0, 1'b1, 3'd2, 1'b0);
        chk("t3_c2_afull", 32'(almost_full), 32'd0);
        chk("t3_c2_aempty", 32'(almost_empty), 32'd0);
        press(1'b0, 1'b1, 3'd3, 1'b0);
        chk("t3_c3_afull", 32'(almost_full), 32'd1);
        chk("t3_c3_full", 32'(full), 32'd0);
        press(1'b0, 1'b1, 3'd4, 1'b0);
        chk("t3_c4_full", 32'(full), 32'd1);
        chk("t3_c4_count", 32'(count), 32'd4);
        press(1'b0, 1'b1, 3'd6, 1'b0);
        chk("t3_ovf", 32'(ovf), 32'd1);
        chk("t3_ovf_count", 32'(count), 32'd4);
        chk("t3_ovf_head", 32'(r_data), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("t3_read_seq", 32'(r_data), 32'(i));
            press(1'b1, 1'b0, 3'd0, 1'b0);
        end
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_empty_rdata", 32'(r_data), 32'd0);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("t3_ovf_clr", 32'(ovf), 32'd0);

        // Test 4: underflow, clear, and set-wins-over-clear
        press(1'b1, 1'b0, 3'd0, 1'b0);
        chk("t4_udf", 32'(udf), 32'd1);
        chk("t4_udf_count", 32'(count), 32'd0);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("t4_udf_clr", 32'(udf), 32'd0);
        press(1'b1, 1'b0, 3'd0, 1'b1);
        chk("t4_set_wins", 32'(udf), 32'd1);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        chk("t4_udf_clr2", 32'(udf), 32'd0);

        // Simultaneous read/write on an empty FIFO: write lands, read flags underflow
        press(1'b1, 1'b1, 3'd6, 1'b0);
        chk("t4_both_empty_count", 32'(count), 32'd1);
        chk("t4_both_empty_udf", 32'(udf), 32'd1);
        chk("t4_both_empty_rdata", 32'(r_data), 32'd6);
        press(1'b1, 1'b0, 3'd0, 1'b1);
        chk("t4_both_empty_drain", 32'(count), 32'd0);
        chk("t4_both_empty_udf_clr", 32'(udf), 32'd0);

        // Test 5: simultaneous read/write on a full FIFO
        for (int i = 1; i <= 4; i++) press(1'b0, 1'b1, 3'(i), 1'b0);
        chk("t5_full", 32'(full), 32'd1);
        press(1'b1, 1'b1, 3'd7, 1'b0);
        chk("t5_count", 32'(count), 32'd4);
        chk("t5_no_ovf", 32'(ovf), 32'd0);
        chk("t5_head", 32'(r_data), 32'd2);
        chk("t5_seq0", 32'(r_data), 32'd2);
        press(1'b1, 1'b0, 3'd0, 1'b0);
        chk("t5_seq1", 32'(r_data), 32'd3);
        press(1'b1, 1'b0, 3'd0, 1'b0);
        chk("t5_seq2", 32'(r_data), 32'd4);
        press(1'b1, 1'b0, 3'd0, 1'b0);
        chk("t5_seq3", 32'(r_data), 32'd7);
        press(1'b1, 1'b0, 3'd0, 1'b0);
        chk("t5_empty", 32'(empty), 32'd1);

        // Test 6: write/read pairs across several pointer wraps
        for (int i = 0; i < 10; i++) begin
            press(1'b0, 1'b1, 3'(i % 8), 1'b0);
            chk("t6_head", 32'(r_data), 32'(i % 8));
            press(1'b1, 1'b0, 3'd0, 1'b0);
            chk("t6_count", 32'(count), 32'd0);
        end
        chk("t6_no_udf", 32'(udf), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
